// File: rtl/ast_demux.sv
// Avalon-ST packet demultiplexer: one input stream steered to TX_DIR outputs through a single output register.
// Optional drop counter port drop_cnt_o is built when AST_DMX_DROP_CNT_EN is defined.
//
// state    | meaning
// S_IDLE   | between packets; only a SOP beat opens a packet, other beats are discarded
// S_IN_PKT | inside a packet; beats follow cur_dir_q until EOP
module ast_demux #(
  parameter int DATA_IN_W     = 64,
  parameter int CHANNEL_W     = 10,
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = 2,
  localparam int EMPTY_W      = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1
) (
  input  logic                                clk_i,
  input  logic                                srst_i,
  input  logic [DIR_SEL_WIDTH-1:0]            dir_i,
  input  logic [DATA_IN_W-1:0]                ast_data_i,
  input  logic                                ast_startofpacket_i,
  input  logic                                ast_endofpacket_i,
  input  logic                                ast_valid_i,
  input  logic [EMPTY_W-1:0]                  ast_empty_i,
  input  logic [CHANNEL_W-1:0]                ast_channel_i,
  output logic                                ast_ready_o,
  output logic [TX_DIR-1:0][DATA_IN_W-1:0]    ast_data_o,
  output logic [TX_DIR-1:0]                   ast_startofpacket_o,
  output logic [TX_DIR-1:0]                   ast_endofpacket_o,
  output logic [TX_DIR-1:0]                   ast_valid_o,
  output logic [TX_DIR-1:0][EMPTY_W-1:0]      ast_empty_o,
  output logic [TX_DIR-1:0][CHANNEL_W-1:0]    ast_channel_o,
  input  logic [TX_DIR-1:0]                   ast_ready_i
`ifdef AST_DMX_DROP_CNT_EN
  ,
  output logic [15:0]                         drop_cnt_o
`endif
);

  typedef enum logic {S_IDLE, S_IN_PKT} state_e;

  state_e                   state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] cur_dir_q, cur_dir_d;
  logic [DIR_SEL_WIDTH-1:0] dir_q, beat_dir;
  logic                     full_q, full_d;
  logic [DATA_IN_W-1:0]     data_q;
  logic                     sop_q, eop_q;
  logic [EMPTY_W-1:0]       empty_q;
  logic [CHANNEL_W-1:0]     chan_q;

  logic sel_rdy, accept, dir_ok, beat_fwd, drain;

  // dir_q only ever holds an in-range direction while full_q is set
  always_comb begin
    sel_rdy = 1'b0;
    for (int d = 0; d < TX_DIR; d++) begin
      if (dir_q == DIR_SEL_WIDTH'(d)) sel_rdy = ast_ready_i[d];
    end
  end

  assign ast_ready_o = srst_i && (!full_q || sel_rdy);
  assign accept      = ast_valid_i && ast_ready_o;
  assign beat_dir    = ast_startofpacket_i ? dir_i : cur_dir_q;
  assign dir_ok      = 32'(beat_dir) < TX_DIR;
  assign beat_fwd    = accept && dir_ok && (ast_startofpacket_i || state_q == S_IN_PKT);
  assign drain       = full_q && sel_rdy;
  assign full_d      = beat_fwd || (full_q && !drain);

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    if (accept) begin
      if (ast_startofpacket_i) begin
        cur_dir_d = dir_i;
        state_d   = ast_endofpacket_i ? S_IDLE : S_IN_PKT;
      end else if (state_q == S_IN_PKT && ast_endofpacket_i) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q   <= S_IDLE;
      cur_dir_q <= '0;
      full_q    <= 1'b0;
      dir_q     <= '0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      full_q    <= full_d;
      if (beat_fwd) begin
        dir_q   <= beat_dir;
        data_q  <= ast_data_i;
        sop_q   <= ast_startofpacket_i;
        eop_q   <= ast_endofpacket_i;
        empty_q <= ast_empty_i;
        chan_q  <= ast_channel_i;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < TX_DIR; d++) begin
      ast_valid_o[d]         = full_q && (dir_q == DIR_SEL_WIDTH'(d));
      ast_data_o[d]          = data_q;
      ast_startofpacket_o[d] = sop_q;
      ast_endofpacket_o[d]   = eop_q;
      ast_empty_o[d]         = empty_q;
      ast_channel_o[d]       = chan_q;
    end
  end

`ifdef AST_DMX_DROP_CNT_EN
  logic        drop_evt;
  logic [15:0] drop_cnt_q;

  // one count per out-of-range packet (at its SOP) and per orphan beat in idle
  assign drop_evt = accept && ((ast_startofpacket_i && !dir_ok) ||
                               (!ast_startofpacket_i && state_q == S_IDLE));

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ast_demux.sv
// Directed bench for ast_demux with a scoreboard of expected output beats checked by a negedge monitor.
module tb_ast_demux;
  localparam int DW = 64;
  localparam int CW = 10;
  localparam int ND = 4;
  localparam int SW = 3;
  localparam int EW = 3;

  logic                  clk = 1'b0;
  logic                  srst;
  logic [SW-1:0]         dir;
  logic [DW-1:0]         data_in;
  logic                  sop_in, eop_in, valid_in;
  logic [EW-1:0]         empty_in;
  logic [CW-1:0]         chan_in;
  logic                  ready_out;
  logic [ND-1:0][DW-1:0] data_out;
  logic [ND-1:0]         sop_out, eop_out, valid_out;
  logic [ND-1:0][EW-1:0] empty_out;
  logic [ND-1:0][CW-1:0] chan_out;
  logic [ND-1:0]         ready_in;
`ifdef AST_DMX_DROP_CNT_EN
  logic [15:0]           drop_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int            d;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] chan;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  ast_demux #(.DATA_IN_W(DW), .CHANNEL_W(CW), .TX_DIR(ND), .DIR_SEL_WIDTH(SW)) dut (
    .clk_i(clk), .srst_i(srst), .dir_i(dir), .ast_data_i(data_in),
    .ast_startofpacket_i(sop_in), .ast_endofpacket_i(eop_in), .ast_valid_i(valid_in),
    .ast_empty_i(empty_in), .ast_channel_i(chan_in), .ast_ready_o(ready_out),
    .ast_data_o(data_out), .ast_startofpacket_o(sop_out), .ast_endofpacket_o(eop_out),
    .ast_valid_o(valid_out), .ast_empty_o(empty_out), .ast_channel_o(chan_out),
    .ast_ready_i(ready_in)
`ifdef AST_DMX_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Any beat presented on an output must be the scoreboard head; popped only when it transfers.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (valid_out[d] === 1'b1) begin
        check("onehot_valid", 64'($countones(valid_out)), 64'd1);
        if (sb.size() == 0) begin
          check("unexpected_beat_dir", 64'(d), 64'hFFFF);
        end else begin
          check("dir", 64'(d), 64'(sb[0].d));
          check("data", data_out[d], sb[0].data);
          check("sop", 64'(sop_out[d]), 64'(sb[0].sop));
          check("eop", 64'(eop_out[d]), 64'(sb[0].eop));
          check("empty", 64'(empty_out[d]), 64'(sb[0].empty));
          check("channel", 64'(chan_out[d]), 64'(sb[0].chan));
          if (ready_in[d]) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input int d, input logic [DW-1:0] dat, input logic s, input logic e,
                       input logic [EW-1:0] em, input logic [CW-1:0] ch);
    dir      = SW'(d);
    data_in  = dat;
    sop_in   = s;
    eop_in   = e;
    empty_in = em;
    chan_in  = ch;
    valid_in = 1'b1;
  endtask

  // Presents one beat and waits (bounded) for acceptance; fwd_dir < 0 means the beat must be dropped.
  task automatic send(input int d, input logic [DW-1:0] dat, input logic s, input logic e,
                      input logic [EW-1:0] em, input logic [CW-1:0] ch, input int fwd_dir,
                      output int waits);
    beat_t b;
    drive(d, dat, s, e, em, ch);
    waits = 0;
    forever begin
      @(negedge clk);
      if (ready_out === 1'b1) break;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 64'(waits), 64'd0);
        @(posedge clk); #1;
        return;
      end
    end
    if (fwd_dir >= 0) begin
      b.d = fwd_dir; b.data = dat; b.sop = s; b.eop = e; b.empty = em; b.chan = ch;
      sb.push_back(b);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w;
`ifdef AST_DMX_DROP_CNT_EN
  logic [15:0] cnt0;
`endif

  initial begin
    srst = 1'b0; ready_in = '1;
    drive(1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 3'd2, 10'h155);

    // reset held with valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 64'(ready_out), 64'd0);
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_data", data_out[1], 64'd0);
    end
    @(posedge clk); #1;
    srst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready_out), 64'd1);
    check("post_rst_sop", 64'(sop_out), 64'd0);
    @(posedge clk); #1;

    // 3-beat packet to dir 2; dir_i moves to 0 after SOP
    send(2, 64'h1111_2222_3333_0001, 1'b1, 1'b0, 3'd0, 10'h012, 2, w);
    send(0, 64'h1111_2222_3333_0002, 1'b0, 1'b0, 3'd5, 10'h013, 2, w);
    send(0, 64'h1111_2222_3333_0003, 1'b0, 1'b1, 3'd3, 10'h014, 2, w);
    idle(2);

    // back-to-back single-beat packets, expecting no stalls
    send(0, 64'hAAAA_0000_0000_0000, 1'b1, 1'b1, 3'd1, 10'h100, 0, w);
    check("b2b_wait0", 64'(w), 64'd0);
    send(1, 64'hAAAA_0000_0000_0001, 1'b1, 1'b1, 3'd2, 10'h101, 1, w);
    check("b2b_wait1", 64'(w), 64'd0);
    send(3, 64'hAAAA_0000_0000_0003, 1'b1, 1'b1, 3'd7, 10'h103, 3, w);
    check("b2b_wait3", 64'(w), 64'd0);
    send(1, 64'hAAAA_0000_0000_0011, 1'b1, 1'b1, 3'd4, 10'h3FF, 1, w);
    check("b2b_wait1b", 64'(w), 64'd0);
    idle(2);

    // backpressure on dir 1 for 4 cycles with the register full
    ready_in[1] = 1'b0;
    send(1, 64'hBBBB_0000_0000_0001, 1'b1, 1'b0, 3'd0, 10'h021, 1, w);
    drive(3, 64'hBBBB_0000_0000_0002, 1'b0, 1'b0, 3'd0, 10'h022);
    repeat (4) begin
      @(negedge clk);
      check("bp_ready", 64'(ready_out), 64'd0);
      check("bp_valid", 64'(valid_out), 64'b0010);
    end
    @(posedge clk); #1;
    ready_in[1] = 1'b1;
    send(3, 64'hBBBB_0000_0000_0002, 1'b0, 1'b0, 3'd0, 10'h022, 1, w);
    send(0, 64'hBBBB_0000_0000_0003, 1'b0, 1'b1, 3'd6, 10'h023, 1, w);
    idle(2);

    // out-of-range direction: whole packet dropped
`ifdef AST_DMX_DROP_CNT_EN
    cnt0 = drop_cnt;
`endif
    send(5, 64'hCCCC_0000_0000_0001, 1'b1, 1'b0, 3'd0, 10'h031, -1, w);
    send(2, 64'hCCCC_0000_0000_0002, 1'b0, 1'b1, 3'd1, 10'h032, -1, w);
    idle(2);
    check("oor_no_valid", 64'(valid_out), 64'd0);
`ifdef AST_DMX_DROP_CNT_EN
    check("drop_cnt_oor", 64'(drop_cnt), 64'(cnt0 + 16'd1));
`endif

    // reset mid-packet after beat 2 of a 4-beat dir-3 packet
    send(3, 64'hDDDD_0000_0000_0001, 1'b1, 1'b0, 3'd0, 10'h041, 3, w);
    send(3, 64'hDDDD_0000_0000_0002, 1'b0, 1'b0, 3'd0, 10'h042, 3, w);
    srst = 1'b0; valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_valid", 64'(valid_out), 64'd0);
    check("midrst_data", data_out[3], 64'd0);
    srst = 1'b1;
`ifdef AST_DMX_DROP_CNT_EN
    check("drop_cnt_rst", 64'(drop_cnt), 64'd0);
`endif
    send(3, 64'hDDDD_0000_0000_0003, 1'b0, 1'b0, 3'd0, 10'h043, -1, w);
    send(3, 64'hDDDD_0000_0000_0004, 1'b0, 1'b1, 3'd0, 10'h044, -1, w);
    idle(2);
    check("orphan_no_valid", 64'(valid_out), 64'd0);
`ifdef AST_DMX_DROP_CNT_EN
    check("drop_cnt_orphan", 64'(drop_cnt), 64'd2);
`endif
    send(0, 64'hEEEE_0000_0000_0001, 1'b1, 1'b1, 3'd5, 10'h050, 0, w);
    idle(5);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
